load_format_unit: RTL and testbench
===================================

// Module: load_format_unit
// PURPOSE
// - Buffered load-data formatter between the memory data register and the register-file write mux.
// - Selects a byte/half/word/dword lane by byte offset, then zero- or sign-extends it to DATA_W.
// - 2-entry FIFO with valid/ready on both sides, so multicycle control can stall either side.
// - Flags misaligned and reserved-size loads and keeps a saturating error count.
// PARAMETERS
// - DATA_W    32  datapath width; 32 or 64 only
// - OFFSET_W  $clog2(DATA_W/8)  byte-offset width (localparam, derived)
// - ERRCNT_W  8   width of the saturating error counter
// PORTS
// - clk          in   1         clock; all state updates on rising edge
// - reset_n      in   1         asynchronous, active-low reset
// - flush        in   1         synchronous clear of FIFO contents; err_count kept
// - in_valid     in   1         request present
// - in_ready     out  1         FIFO can accept a request
// - raw_data     in   DATA_W    raw memory word
// - byte_offset  in   OFFSET_W  address low bits
// - size         in   2         00 word(32b), 01 half, 10 byte, 11 dword (DATA_W=64 only; reserved at 32)
// - sign_ext     in   1         1 = sign-extend, 0 = zero-extend
// - out_valid    out  1         FIFO head valid
// - out_ready    in   1         consumer accepts head
// - out_data     out  DATA_W    formatted data at head
// - out_err      out  1         head entry was misaligned or reserved
// - err_count    out  ERRCNT_W  saturating count of erroneous accepted requests
// BEHAVIOUR
// - Reset (reset_n=0, async): FIFO empty, out_valid=0, out_data=0, out_err=0, err_count=0; in_ready=1 after release.
// - Push = in_valid & in_ready; pop = out_valid & out_ready. Formatting is done before the FIFO write.
// - Latency: request pushed in cycle N is visible at out_* in cycle N+1 if FIFO was empty. No combinational in->out path.
// - in_ready = (count < 2), from registered count only; never depends on out_ready.
// - count 1: push & pop in the same cycle -> count stays 1, new entry becomes head next cycle.
// - count 2: in_ready=0; a pop frees a slot, and in_ready=1 in the following cycle.
// - FIFO order is strict; out_data/out_err hold stable while out_valid & ~out_ready.
// - flush: count=0, out_valid=0 next cycle; flush wins over a simultaneous push/pop; err_count unaffected.
// - Lane selection: lane = raw_data >> (8*byte_offset); the low 8/16/32/64 bits of lane are taken.
// - Extension: sign_ext=1 replicates the lane MSB up to DATA_W-1; sign_ext=0 fills with 0. Dword ignores sign_ext.
// - Alignment: byte any offset; half needs offset[0]=0; word needs offset[1:0]=0; dword needs offset=0.
// - Error entry: out_err=1, out_data=0. size=11 with DATA_W=32 is always an error.
// - err_count increments on each pushed error entry; saturates at all-ones and never wraps.
// - Reset asserted mid-transfer discards all entries immediately; no partial output.
// CONFIGURATION
// - LOAD_FORMAT_UNALIGNED_EN defined: misaligned half/word/dword loads are accepted. Bytes are gathered from
//   byte_offset upward, wrapping modulo DATA_W/8 (byte k = raw byte (offset+k) mod N). out_err=1 only for reserved size.
// - Not defined: misalignment is an error, as in BEHAVIOUR.
// TESTING
// - DATA_W=32, raw=32'h8899_AABB, offset=0, size=10, sign_ext=1 -> next cycle out_data=32'hFFFF_FFBB, out_err=0.
// - raw=32'h8899_AABB, offset=2, size=01, sign_ext=0 -> out_data=32'h0000_8899; sign_ext=1 -> 32'hFFFF_8899.
// - offset=1, size=01, macro off -> out_err=1, out_data=0, err_count 0->1; macro on -> out_data=32'h0000_99AA, out_err=0.
// - out_ready=0, push 3 back-to-back -> in_ready=0 after 2 pushes, 3rd held; release -> 3 outputs in order, none lost.
// - count=1, simultaneous push & pop for 10 cycles -> count stays 1, one output per cycle; flush -> out_valid=0 next cycle.
// - 256 error pushes with ERRCNT_W=8 -> err_count=8'hFF, stays there; reset_n pulse mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/load_format_unit.sv
// load_format_unit: selects and zero/sign-extends a load lane, then buffers it in a 2-entry valid/ready FIFO.
// Optional macro LOAD_FORMAT_UNALIGNED_EN: misaligned loads gather bytes with wraparound instead of erroring.
module load_format_unit #(
    parameter int DATA_W    = 32,
    parameter int ERRCNT_W  = 8,
    localparam int OFFSET_W = $clog2(DATA_W/8)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   raw_data,
    input  logic [OFFSET_W-1:0] byte_offset,
    input  logic [1:0]          size,
    input  logic                sign_ext,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_err,
    output logic [ERRCNT_W-1:0] err_count
);
    logic [DATA_W-1:0]   lane, hi, fmt_data;
    logic [6:0]          w;
    logic                sgn, mis, rsv, fmt_err;
    logic [DATA_W:0]     mem_q [2];
    logic                rd_q, rd_d, wr_q, wr_d, push, pop;
    logic [1:0]          cnt_q, cnt_d;
    logic [ERRCNT_W-1:0] errc_q, errc_d;

    always_comb begin
`ifdef LOAD_FORMAT_UNALIGNED_EN
        lane = DATA_W'({raw_data, raw_data} >> {byte_offset, 3'b000});
        mis  = 1'b0;
`else
        lane = raw_data >> {byte_offset, 3'b000};
        mis  = (size == 2'b01 && byte_offset[0]) || (size == 2'b00 && |byte_offset[1:0]) ||
               (size == 2'b11 && |byte_offset);
`endif
        rsv      = (DATA_W == 32) && (size == 2'b11);
        w        = size == 2'b10 ? 7'd8 : size == 2'b01 ? 7'd16 : size == 2'b00 ? 7'd32 : 7'd64;
        // hi masks the bits above the selected lane; it is empty for full-width loads
        hi       = {DATA_W{1'b1}} << w;
        sgn      = sign_ext && (w < 7'(DATA_W)) && |(lane & (DATA_W'(1) << (w - 7'd1)));
        fmt_err  = mis | rsv;
        fmt_data = fmt_err ? '0 : (lane & ~hi) | (sgn ? hi : '0);
    end

    assign in_ready  = cnt_q != 2'd2;
    assign out_valid = cnt_q != 2'd0;
    assign {out_err, out_data} = out_valid ? mem_q[rd_q] : '0;
    assign err_count = errc_q;

    always_comb begin
        push   = in_valid & in_ready;
        pop    = out_valid & out_ready;
        rd_d   = flush ? 1'b0 : rd_q ^ pop;
        wr_d   = flush ? 1'b0 : wr_q ^ push;
        cnt_d  = flush ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
        errc_d = (push && fmt_err && !(&errc_q)) ? errc_q + ERRCNT_W'(1) : errc_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q  <= '{default: '0};
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            cnt_q  <= 2'd0;
            errc_q <= '0;
        end else begin
            if (push && !flush) mem_q[wr_q] <= {fmt_err, fmt_data};
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            errc_q <= errc_d;
        end
    end
endmodule

// File: tb/tb_load_format_unit.sv
// tb_load_format_unit: randomized + directed scoreboard bench for load_format_unit (DATA_W=32, ERRCNT_W=8).
module tb_load_format_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, sign_ext = 1'b0;
    logic [31:0] raw_data = '0;
    logic [1:0]  byte_offset = '0, size = '0;
    logic        in_ready, out_valid, out_err;
    logic [31:0] out_data;
    logic [7:0]  err_count;

    int tests = 0, fails = 0;
    logic [32:0] q[$];
    int ecnt = 0;

    load_format_unit #(.DATA_W(32), .ERRCNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .raw_data(raw_data), .byte_offset(byte_offset), .size(size), .sign_ext(sign_ext),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: assemble N bytes starting at the offset (wrapping when unaligned loads are enabled), then extend.
    function automatic logic [32:0] model(logic [31:0] raw, int off, int sz, bit sx);
        int n;
        logic [31:0] v;
        n = sz == 2 ? 1 : sz == 1 ? 2 : sz == 0 ? 4 : 8;
        if (sz == 3) return {1'b1, 32'h0};
`ifndef LOAD_FORMAT_UNALIGNED_EN
        if (off % n != 0) return {1'b1, 32'h0};
`endif
        v = 0;
        for (int k = 0; k < n; k++) v |= ((raw >> (8 * ((off + k) % 4))) & 32'hFF) << (8 * k);
        if (sx && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
        return {1'b0, v};
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
            ecnt = 0;
        end else begin
            check("in_ready", 64'(in_ready), 64'(q.size() < 2));
            check("out_valid", 64'(out_valid), 64'(q.size() != 0));
            check("err_count", 64'(err_count), 64'(ecnt));
            if (!out_valid) check("idle_out", {out_err, out_data}, 64'h0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("unexpected_out", 64'(1), 64'(0));
                else check("out_entry", {out_err, out_data}, 64'(q[0]));
            end
            if (in_valid && in_ready && model(raw_data, int'(byte_offset), int'(size), sign_ext) >> 32 != 0 && ecnt != 255)
                ecnt++;
            if (flush) q.delete();
            else begin
                if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
                if (in_valid && in_ready) q.push_back(model(raw_data, int'(byte_offset), int'(size), sign_ext));
            end
        end
    end

    task automatic drive(logic [31:0] r, logic [1:0] o, logic [1:0] s, logic x);
        in_valid = 1'b1; raw_data = r; byte_offset = o; size = s; sign_ext = x;
    endtask

    task automatic wait_acc();
        bit acc;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
            if (acc) return;
        end
        check("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic send(logic [31:0] r, logic [1:0] o, logic [1:0] s, logic x);
        drive(r, o, s, x);
        wait_acc();
    endtask

    task automatic dir(string name, logic [31:0] r, logic [1:0] o, logic [1:0] s, logic x,
                       logic [31:0] ed, logic ee);
        out_ready = 1'b1;
        send(r, o, s, x);
        in_valid = 1'b0;
        @(negedge clk);
        check({name, "_valid"}, 64'(out_valid), 64'(1));
        check({name, "_data"}, 64'(out_data), 64'(ed));
        check({name, "_err"}, 64'(out_err), 64'(ee));
        @(posedge clk); #1;
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #1;
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_data", {out_err, out_data}, 64'h0);
        check("rst_errcnt", 64'(err_count), 64'(0));
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        check("rst_in_ready", 64'(in_ready), 64'(1));

        dir("byte_sx", 32'h8899_AABB, 2'd0, 2'b10, 1'b1, 32'hFFFF_FFBB, 1'b0);
        dir("half_zx", 32'h8899_AABB, 2'd2, 2'b01, 1'b0, 32'h0000_8899, 1'b0);
        dir("half_sx", 32'h8899_AABB, 2'd2, 2'b01, 1'b1, 32'hFFFF_8899, 1'b0);
`ifdef LOAD_FORMAT_UNALIGNED_EN
        dir("half_mis", 32'h8899_AABB, 2'd1, 2'b01, 1'b0, 32'h0000_99AA, 1'b0);
        dir("word_wrap", 32'h8899_AABB, 2'd3, 2'b00, 1'b0, 32'h99AA_BB88, 1'b0);
`else
        dir("half_mis", 32'h8899_AABB, 2'd1, 2'b01, 1'b0, 32'h0, 1'b1);
        check("errcnt_mis", 64'(err_count), 64'(1));
        dir("word_mis", 32'h8899_AABB, 2'd2, 2'b00, 1'b0, 32'h0, 1'b1);
`endif
        dir("dword_rsv", 32'h1234_5678, 2'd0, 2'b11, 1'b0, 32'h0, 1'b1);
        dir("word_ok", 32'h8123_4567, 2'd0, 2'b00, 1'b1, 32'h8123_4567, 1'b0);

        // back-pressure: two fill the FIFO, the third is held until the consumer resumes
        out_ready = 1'b0;
        send(32'h0000_0011, 2'd0, 2'b10, 1'b0);
        send(32'h0000_2200, 2'd1, 2'b10, 1'b0);
        drive(32'h0033_0000, 2'd2, 2'b10, 1'b0);
        repeat (3) @(posedge clk);
        #1 check("full_in_ready", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        wait_acc();
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("drained", 64'(out_valid), 64'(0));

        // streaming at count 1, then flush
        for (int i = 0; i < 11; i++) send($urandom, 2'($urandom), 2'b10, 1'($urandom));
        check("stream_valid", 64'(out_valid), 64'(1));
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        check("flush_valid", 64'(out_valid), 64'(0));

        // error saturation
        out_ready = 1'b1;
        for (int i = 0; i < 260; i++) send($urandom, 2'($urandom), 2'b11, 1'b0);
        in_valid = 1'b0;
        @(posedge clk); #1 check("errcnt_sat", 64'(err_count), 64'hFF);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            flush     = ($urandom_range(0, 29) == 0);
            in_valid  = !flush && $urandom_range(0, 2) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            raw_data  = $urandom;
            byte_offset = 2'($urandom);
            size      = 2'($urandom);
            sign_ext  = 1'($urandom);
        end
        flush = 1'b0;

        // reset mid-stream with entries pending
        out_ready = 1'b0;
        @(posedge clk); #1 in_valid = 1'b1; size = 2'b10;
        @(posedge clk); #1 in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'(0));
        check("midrst_data", {out_err, out_data}, 64'h0);
        check("midrst_errcnt", 64'(err_count), 64'(0));
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        dir("post_rst", 32'hCAFE_F00D, 2'd1, 2'b10, 1'b0, 32'h0000_00F0, 1'b0);

        out_ready = 1'b1; in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("final_empty", 64'(q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
